spi_slave_resp: RTL and testbench
=================================

Name: spi_slave_resp

Overview:
- SPI responder (slave) for the on-chip SPI master's pad interface: SPIMCLK, SPIMCSN, SPIMSDO and SPIMSDI.
- Used on the bench side and in loopback fixtures.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first.
- SPI inputs are oversampled on the system clock. SDO and its output enable feed a tristate pad cell.
- Received words go out on a valid/ready stream. Transmit words come in on a valid/ready stream.

Parameters:
- DATA_WIDTH, 8: bits per SPI word, range 4..32.
- SYNC_STAGES, 2: synchroniser depth on sclk, csn and sdi, range 2..3.
- IDLE_PATTERN, all ones: word shifted out when no transmit data is held.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- spi_sclk  in  1  SPI clock from master (SPIMCLK).
- spi_csn  in  1  chip select, active low (SPIMCSN).
- spi_mosi  in  1  master data out (SPIMSDO).
- spi_miso  out  1  slave data to master (SPIMSDI).
- spi_miso_oe  out  1  tristate enable for spi_miso.
- rx_data  out  DATA_WIDTH  received word.
- rx_valid  out  1  rx_data valid.
- rx_ready  in  1  consumer accepts rx_data.
- rx_overrun  out  1  one-cycle pulse when a received word is dropped.
- tx_data  in  DATA_WIDTH  next word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  transmit holding register empty.
- tx_underrun  out  1  one-cycle pulse when IDLE_PATTERN is loaded instead of user data.
- busy  out  1  transaction in progress (CSN active as seen after synchronisation).

Behaviour:
- Interface decided: one clock, clk; reset rst, synchronous, active-high.
- Reset values:
  - All outputs 0, except tx_ready=1.
  - spi_miso=1, spi_miso_oe=0.
  - FSM in IDLE, bit counter 0, holding registers empty.
- Input synchronisation:
  - sclk, csn and mosi each pass through SYNC_STAGES flops, then one extra flop for edge detection.
  - Rise and fall strobes are single-cycle.
  - Allowed SCLK: high and low phases each ≥ SYNC_STAGES+2 clk cycles.
  - CSN fall to first SCLK rise: ≥ SYNC_STAGES+3 clk cycles.
- FSM IDLE -> LOAD -> SHIFT -> IDLE:
  - IDLE: spi_miso_oe=0, busy=0. On synchronised CSN fall, go to LOAD.
  - LOAD (1 cycle): load the tx shifter from the holding register if full, clear it, tx_ready=1. If empty, load IDLE_PATTERN and pulse tx_underrun. Drive spi_miso=shifter MSB, spi_miso_oe=1, busy=1, bit count=0. Go to SHIFT.
  - SHIFT, SCLK rise: shift mosi into the rx shifter LSB and increment the bit count.
  - SHIFT, SCLK rise that completes a word (count reaches DATA_WIDTH): copy the word to the rx holding register and set count to 0. This happens on the same cycle as the final shift; rx_valid is asserted the next cycle.
  - SHIFT, SCLK fall with count≠0: shift the tx shifter left, so spi_miso shows the next bit.
  - SHIFT, SCLK fall with count=0 after at least one full word: reload the tx shifter as in LOAD (back-to-back words, no gap).
  - SHIFT, CSN rise: go to IDLE. spi_miso_oe=0 the next cycle. Any partial rx word is discarded with no rx_valid. The tx word already in the shifter is consumed and not replayed.
- RX stream:
  - rx_valid stays high until rx_valid&rx_ready.
  - If a new word completes while rx_valid=1 and rx_ready=0: keep the old word, drop the new one, pulse rx_overrun.
  - Word completion on the same cycle as a handshake: new word is latched, rx_valid stays 1, no overrun.
- TX stream:
  - tx_ready = holding register empty. A write is accepted on tx_valid&tx_ready.
  - Accept and load in the same cycle: the load sees the register empty (IDLE_PATTERN) and the accepted word is held for the next word.
- Reset mid-transaction: immediate return to reset values. The master sees spi_miso_oe drop after one clk.

Optional Feature:
- Macro SPI_SLAVE_ECHO_EN.
- When defined: a load with an empty transmit holding register uses the last completed rx word (IDLE_PATTERN if none since reset) instead of IDLE_PATTERN. tx_underrun still pulses.
- When undefined: IDLE_PATTERN is used. No echo register is synthesised.

Test Plan:
- Reset, then single 8-bit transfer:
  - Stimulus: tx_data=0xA5 preloaded, master sends 0x3C with SCLK half period 8 clk.
  - Required: master reads 0xA5; rx_data=0x3C with one rx_valid; no underrun.
- Back-to-back transfer:
  - Stimulus: three words 0x01, 0x02, 0x03 under one CSN, tx words 0x11, 0x22 supplied.
  - Required: master reads 0x11, 0x22, IDLE_PATTERN; one tx_underrun on word 3; rx order 0x01, 0x02, 0x03.
- RX overrun:
  - Stimulus: rx_ready=0, two words 0x55 then 0xAA.
  - Required: rx_data=0x55 held, one rx_overrun pulse.
- Abort:
  - Stimulus: CSN deasserted after 5 bits.
  - Required: no rx_valid; spi_miso_oe=0 within SYNC_STAGES+2 clk; next transfer starts a clean word.
- Reset mid-transfer:
  - Stimulus: rst pulsed after bit 3.
  - Required: all outputs at reset values the cycle after rst; the following transfer is correct.
- Echo (SPI_SLAVE_ECHO_EN defined):
  - Stimulus: send 0x9E, then a second word with no tx data.
  - Required: master reads 0x9E on the second word.

Source files
------------

// File: rtl/spi_slave_resp.sv
// SPI mode-0 responder: oversampled pad inputs, valid/ready rx and tx word streams.
// Optional macro SPI_SLAVE_ECHO_EN: loads with no pending tx word replay the last received word.

module spi_slave_resp #(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    SYNC_STAGES  = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_PATTERN = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sclk,
  input  logic                  spi_csn,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_overrun,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  // Synchroniser chains; the top bit of each is the extra edge-detect flop.
  logic [SYNC_STAGES:0] sclk_pipe_reg;
  logic [SYNC_STAGES:0] csn_pipe_reg;
  logic [SYNC_STAGES:0] mosi_pipe_reg;

  // csn resets low so a master already holding CSN low at reset release
  // does not produce a spurious falling edge mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_pipe_reg <= '0;
      csn_pipe_reg  <= '0;
      mosi_pipe_reg <= '0;
    end else begin
      sclk_pipe_reg <= {sclk_pipe_reg[SYNC_STAGES-1:0], spi_sclk};
      csn_pipe_reg  <= {csn_pipe_reg[SYNC_STAGES-1:0], spi_csn};
      mosi_pipe_reg <= {mosi_pipe_reg[SYNC_STAGES-1:0], spi_mosi};
    end
  end

  logic sclk_rise;
  logic sclk_fall;
  logic csn_sync;
  logic csn_fall;
  logic mosi_bit;

  assign sclk_rise = sclk_pipe_reg[SYNC_STAGES-1] & ~sclk_pipe_reg[SYNC_STAGES];
  assign sclk_fall = ~sclk_pipe_reg[SYNC_STAGES-1] & sclk_pipe_reg[SYNC_STAGES];
  assign csn_sync  = csn_pipe_reg[SYNC_STAGES-1];
  assign csn_fall  = ~csn_pipe_reg[SYNC_STAGES-1] & csn_pipe_reg[SYNC_STAGES];
  assign mosi_bit  = mosi_pipe_reg[SYNC_STAGES];

  state_t                  state_reg;
  state_t                  state_next;
  logic [CNT_W-1:0]        bit_cnt_reg;
  logic                    full_word_reg;
  logic [DATA_WIDTH-1:0]   tx_shift_reg;
  logic [DATA_WIDTH-1:0]   tx_hold_reg;
  logic                    tx_full_reg;
  logic [DATA_WIDTH-2:0]   rx_shift_reg;
  logic [DATA_WIDTH-1:0]   rx_data_reg;
  logic                    rx_valid_reg;
  logic                    rx_overrun_reg;
  logic                    tx_underrun_reg;

  logic                    load_en;
  logic                    rx_shift_en;
  logic                    tx_shift_en;
  logic                    word_done;
  logic [DATA_WIDTH-1:0]   rx_word;
  logic [DATA_WIDTH-1:0]   fill_word;
  logic [DATA_WIDTH-1:0]   load_word;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // CSN level (not edge) ends SHIFT, so a very short CSN pulse cannot strand the FSM.
  always_comb begin
    state_next  = state_reg;
    load_en     = 1'b0;
    rx_shift_en = 1'b0;
    tx_shift_en = 1'b0;
    case (state_reg)
      IDLE: begin
        if (csn_fall) state_next = LOAD;
      end
      LOAD: begin
        load_en    = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        if (csn_sync) begin
          state_next = IDLE;
        end else if (sclk_rise) begin
          rx_shift_en = 1'b1;
        end else if (sclk_fall) begin
          if (bit_cnt_reg != '0) tx_shift_en = 1'b1;
          else if (full_word_reg) load_en = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign word_done = rx_shift_en && (bit_cnt_reg == LAST_BIT);
  assign rx_word   = {rx_shift_reg, mosi_bit};
  assign load_word = tx_full_reg ? tx_hold_reg : fill_word;

`ifdef SPI_SLAVE_ECHO_EN
  logic [DATA_WIDTH-1:0] echo_reg;

  always_ff @(posedge clk) begin
    if (rst)            echo_reg <= IDLE_PATTERN;
    else if (word_done) echo_reg <= rx_word;
  end

  assign fill_word = echo_reg;
`else
  assign fill_word = IDLE_PATTERN;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_reg     <= '0;
      full_word_reg   <= 1'b0;
      tx_shift_reg    <= IDLE_PATTERN;
      tx_hold_reg     <= '0;
      tx_full_reg     <= 1'b0;
      rx_shift_reg    <= '0;
      rx_data_reg     <= '0;
      rx_valid_reg    <= 1'b0;
      rx_overrun_reg  <= 1'b0;
      tx_underrun_reg <= 1'b0;
    end else begin
      rx_overrun_reg  <= 1'b0;
      tx_underrun_reg <= 1'b0;

      if (state_reg == LOAD) begin
        bit_cnt_reg   <= '0;
        full_word_reg <= 1'b0;
      end

      if (load_en) begin
        tx_shift_reg <= load_word;
        if (tx_full_reg) tx_full_reg     <= 1'b0;
        else             tx_underrun_reg <= 1'b1;
      end else if (tx_shift_en) begin
        tx_shift_reg <= {tx_shift_reg[DATA_WIDTH-2:0], 1'b1};
      end

      // An accept never coincides with a load that empties the register.
      if (tx_valid && !tx_full_reg) begin
        tx_hold_reg <= tx_data;
        tx_full_reg <= 1'b1;
      end

      if (rx_shift_en) begin
        rx_shift_reg <= rx_word[DATA_WIDTH-2:0];
        if (word_done) begin
          bit_cnt_reg   <= '0;
          full_word_reg <= 1'b1;
        end else begin
          bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
        end
      end

      if (word_done) begin
        if (!rx_valid_reg || rx_ready) begin
          rx_data_reg  <= rx_word;
          rx_valid_reg <= 1'b1;
        end else begin
          rx_overrun_reg <= 1'b1;
        end
      end else if (rx_valid_reg && rx_ready) begin
        rx_valid_reg <= 1'b0;
      end
    end
  end

  assign busy        = (state_reg != IDLE);
  assign spi_miso_oe = busy;
  assign spi_miso    = (state_reg == IDLE) ? 1'b1 : tx_shift_reg[DATA_WIDTH-1];
  assign rx_data     = rx_data_reg;
  assign rx_valid    = rx_valid_reg;
  assign rx_overrun  = rx_overrun_reg;
  assign tx_ready    = ~tx_full_reg;
  assign tx_underrun = tx_underrun_reg;

endmodule

// File: tb/tb_spi_slave_resp.sv
// Self-checking bench for spi_slave_resp: directed frames plus random frames
// checked against a word-level model of loads, underruns, overruns and echo.

module tb_spi_slave_resp;

  localparam int             W        = 8;
  localparam int             S        = 2;
  localparam int             HP       = 8;
  localparam int             IDLE_GAP = 20;
  localparam logic [W-1:0]   IDLE     = 8'hFF;

  logic         clk = 1'b0;
  logic         rst;
  logic         spi_sclk;
  logic         spi_csn;
  logic         spi_mosi;
  logic         spi_miso;
  logic         spi_miso_oe;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic         rx_overrun;
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         tx_underrun;
  logic         busy;

  always #5 clk = ~clk;

  spi_slave_resp #(
    .DATA_WIDTH   (W),
    .SYNC_STAGES  (S),
    .IDLE_PATTERN (IDLE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_sclk    (spi_sclk),
    .spi_csn     (spi_csn),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_overrun  (rx_overrun),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_underrun (tx_underrun),
    .busy        (busy)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard state
  logic [W-1:0] rx_exp[$];
  logic [W-1:0] tx_q[$];
  logic [W-1:0] m_rx[$];
  logic [W-1:0] f_mosi[3];
  logic [W-1:0] f_tx[3];
  logic [W-1:0] fill_model;
  int           rx_seen = 0;
  int           ovr_cnt = 0;
  int           und_cnt = 0;
  int           frame_no = 0;

  // Receive monitor and pulse counters
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid && rx_ready) begin
        rx_seen++;
        if (rx_exp.size() > 0) check_val("rx_data", rx_data, rx_exp.pop_front());
      end
      if (rx_overrun)  ovr_cnt++;
      if (tx_underrun) und_cnt++;
    end
  end

  // Transmit feeder: presents tx_q head until accepted
  initial begin
    bit acc;
    tx_valid = 1'b0;
    tx_data  = '0;
    forever begin
      @(negedge clk);
      acc = tx_valid && tx_ready && !rst;
      @(posedge clk);
      #1;
      if (acc && tx_q.size() > 0) void'(tx_q.pop_front());
      tx_valid = (tx_q.size() > 0);
      tx_data  = tx_valid ? tx_q[0] : '0;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_miso"},     spi_miso,    1);
    check_val({tag, "_miso_oe"},  spi_miso_oe, 0);
    check_val({tag, "_busy"},     busy,        0);
    check_val({tag, "_rx_valid"}, rx_valid,    0);
    check_val({tag, "_rx_data"},  rx_data,     0);
    check_val({tag, "_overrun"},  rx_overrun,  0);
    check_val({tag, "_underrun"}, tx_underrun, 0);
    check_val({tag, "_tx_ready"}, tx_ready,    1);
  endtask

  // Mode-0 master. CSN is raised while SCLK is still high after the last bit,
  // then SCLK returns low. cut_bits>0 stops the frame early; do_rst pulses rst there.
  task automatic spi_xfer(input int nwords, input int cut_bits, input bit do_rst);
    int           total;
    int           k;
    logic [W-1:0] rbits;
    rbits = '0;
    total = (cut_bits > 0) ? cut_bits : nwords * W;
    m_rx.delete();
    spi_mosi = f_mosi[0][W-1];
    spi_csn  = 1'b0;
    repeat (S + 6) @(posedge clk);
    #1;
    for (int i = 0; i < total; i++) begin
      spi_mosi = f_mosi[i / W][W - 1 - (i % W)];
      repeat (HP) @(posedge clk);
      #1;
      rbits    = {rbits[W-2:0], spi_miso};
      spi_sclk = 1'b1;
      if (i == 0) begin
        check_val("oe_active", spi_miso_oe, 1);
        check_val("busy_active", busy, 1);
      end
      if ((i % W) == W - 1) m_rx.push_back(rbits);
      repeat (HP) @(posedge clk);
      #1;
      if (i != total - 1) spi_sclk = 1'b0;
    end
    if (do_rst) begin
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_reset_vals("midrst");
      rst = 1'b0;
    end
    spi_csn = 1'b1;
    if (cut_bits > 0 && !do_rst) begin
      k = 0;
      while (spi_miso_oe && k < S + 2) begin
        @(posedge clk);
        #1;
        k++;
      end
      check_val("abort_oe_off", spi_miso_oe, 0);
    end
    repeat (HP) @(posedge clk);
    #1;
    spi_sclk = 1'b0;
    repeat (IDLE_GAP) @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] model_fill();
`ifdef SPI_SLAVE_ECHO_EN
    return fill_model;
`else
    return IDLE;
`endif
  endfunction

  // One frame: model the word-level outcome, run the master, compare.
  task automatic run_frame(input int nwords, input int ntx, input int cut_bits, input bit do_rst);
    logic [W-1:0] exp_miso[3];
    int loads, exp_und, exp_ovr, exp_seen;
    int und0, ovr0, seen0, k;
    bit complete;
    complete = (cut_bits == 0) && !do_rst;
    loads    = complete ? nwords : 1;
    exp_und  = 0;
    for (int i = 0; i < loads; i++) begin
      if (i < ntx) begin
        exp_miso[i] = f_tx[i];
      end else begin
        exp_miso[i] = model_fill();
        exp_und++;
      end
      if (complete) fill_model = f_mosi[i];
    end
    if (do_rst) fill_model = IDLE;
    exp_ovr  = 0;
    exp_seen = 0;
    if (complete) begin
      if (rx_ready) begin
        for (int i = 0; i < nwords; i++) rx_exp.push_back(f_mosi[i]);
        exp_seen = nwords;
      end else begin
        rx_exp.push_back(f_mosi[0]);
        exp_ovr = nwords - 1;
      end
    end
    und0  = und_cnt;
    ovr0  = ovr_cnt;
    seen0 = rx_seen;
    for (int i = 0; i < ntx; i++) tx_q.push_back(f_tx[i]);
    if (ntx > 0) begin
      k = 0;
      while (tx_ready && k < 50) begin
        @(posedge clk);
        #1;
        k++;
      end
      check_val("tx_preload", tx_ready, 0);
    end
    spi_xfer(nwords, cut_bits, do_rst);
    check_val("miso_words", m_rx.size(), complete ? nwords : 0);
    for (int i = 0; i < m_rx.size() && i < loads; i++) check_val("miso_word", m_rx[i], exp_miso[i]);
    check_val("underruns", und_cnt - und0, exp_und);
    check_val("overruns", ovr_cnt - ovr0, exp_ovr);
    check_val("rx_count", rx_seen - seen0, exp_seen);
    if (rx_ready) check_val("rx_pending", rx_exp.size(), 0);
    $display("[TB] frame %0d: words=%0d tx=%0d cut=%0d rst=%0d mosi0=%02h miso0=%02h",
             frame_no, nwords, ntx, cut_bits, do_rst, f_mosi[0],
             (m_rx.size() > 0) ? m_rx[0] : 8'h00);
    frame_no++;
  endtask

  initial begin
    int nw, nt, ct;
    rst        = 1'b1;
    spi_sclk   = 1'b0;
    spi_csn    = 1'b1;
    spi_mosi   = 1'b0;
    rx_ready   = 1'b1;
    fill_model = IDLE;
    repeat (4) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Single word
    f_mosi[0] = 8'h3C; f_tx[0] = 8'hA5;
    run_frame(1, 1, 0, 0);

    // Back-to-back under one CSN
    f_mosi[0] = 8'h01; f_mosi[1] = 8'h02; f_mosi[2] = 8'h03;
    f_tx[0]   = 8'h11; f_tx[1]   = 8'h22;
    run_frame(3, 2, 0, 0);

    // Overrun: consumer stalled across two words
    rx_ready  = 1'b0;
    f_mosi[0] = 8'h55; f_mosi[1] = 8'hAA;
    run_frame(2, 0, 0, 0);
    check_val("ovr_valid_held", rx_valid, 1);
    check_val("ovr_data_held", rx_data, 8'h55);
    rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("ovr_drained", rx_exp.size(), 0);
    check_val("ovr_valid_clr", rx_valid, 0);

    // Abort after 5 bits, then a clean word
    f_mosi[0] = 8'hC3;
    run_frame(1, 0, 5, 0);
    f_mosi[0] = 8'h5A; f_tx[0] = 8'h69;
    run_frame(1, 1, 0, 0);

    // Reset after bit 3, then a clean word
    f_mosi[0] = 8'hF0;
    run_frame(1, 0, 3, 1);
    f_mosi[0] = 8'h96; f_tx[0] = 8'h7E;
    run_frame(1, 1, 0, 0);

    // Echo pattern: second word has no tx data
    f_mosi[0] = 8'h9E; f_tx[0] = 8'h3B;
    run_frame(1, 1, 0, 0);
    f_mosi[0] = 8'h47;
    run_frame(1, 0, 0, 0);
`ifdef SPI_SLAVE_ECHO_EN
    if (m_rx.size() > 0) check_val("echo_word", m_rx[0], 8'h9E);
`endif

    // Random frames
    for (int f = 0; f < 24; f++) begin
      nw = $urandom_range(1, 3);
      nt = $urandom_range(0, nw);
      ct = ($urandom_range(0, 5) == 0) ? $urandom_range(1, W - 1) : 0;
      if (ct > 0 && nt > 1) nt = 1;
      for (int i = 0; i < 3; i++) begin
        f_mosi[i] = W'($urandom);
        f_tx[i]   = W'($urandom);
      end
      run_frame(nw, nt, ct, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
